// File: rtl/mef_contador_pkg.sv
// Shared definitions for the bottling-line controllers: handshake states,
// box size and BCD digit width.
package mef_contador_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } estado_t;

    localparam int GARRAFAS_POR_CAIXA = 12;
    localparam int BCD_W              = 4;

endpackage

// File: rtl/contador_bcd_duzias.sv
// Dozens counter kept in binary and BCD side by side, saturating at a limit.
// A clear and an increment on the same edge leave the count at one.
module contador_bcd_duzias
    import mef_contador_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [6:0]       sat_limit,
    output logic [6:0]       binario,
    output logic [BCD_W-1:0] dezenas,
    output logic [BCD_W-1:0] unidades,
    output logic             estouro
);

    logic [6:0]       bin_n;
    logic [BCD_W-1:0] dez_n;
    logic [BCD_W-1:0] uni_n;

    assign estouro = inc && !clr && (binario == sat_limit);

    always_comb begin
        bin_n = binario;
        dez_n = dezenas;
        uni_n = unidades;
        if (clr) begin
            bin_n = '0;
            dez_n = '0;
            uni_n = '0;
        end
        if (inc && !estouro) begin
            bin_n = bin_n + 7'd1;
            if (uni_n == 4'd9) begin
                uni_n = '0;
                dez_n = dez_n + 4'd1;
            end else begin
                uni_n = uni_n + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            binario  <= '0;
            dezenas  <= '0;
            unidades <= '0;
        end else begin
            binario  <= bin_n;
            dezenas  <= dez_n;
            unidades <= uni_n;
        end
    end

endmodule

// File: rtl/mef_contador.sv
// Bottle-counting responder: four-phase handshake with the main controller,
// bottles per box, completed boxes (binary + BCD), stock alarm and overflow flag.
module mef_contador
    import mef_contador_pkg::*;
#(
    parameter int MAX_DUZIAS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count,
    input  logic             limpar,
    input  logic             esvaziar,
    output logic             cont_done,
    output logic             alarme,
    output logic [3:0]       garrafas,
    output logic [6:0]       duzias,
    output logic [BCD_W-1:0] duzias_dez,
    output logic [BCD_W-1:0] duzias_uni,
    output logic             excedente
);

    localparam logic [6:0] LIMITE    = 7'(MAX_DUZIAS);
    localparam logic [6:0] LIMITE_M1 = 7'(MAX_DUZIAS - 1);
    localparam logic [3:0] ULTIMA    = 4'(GARRAFAS_POR_CAIXA - 1);

    estado_t    estado;
    estado_t    estado_n;
    logic       inc;
    logic       caixa;
    logic       estouro;
    logic       alarme_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_n;
        end
    end

    // One increment per request: only the IDLE->ACK transition counts.
    always_comb begin
        estado_n = estado;
        inc      = 1'b0;
        case (estado)
            IDLE: begin
                if (count) begin
                    inc      = 1'b1;
                    estado_n = ACK;
                end
            end
            ACK: begin
                if (!count) begin
                    estado_n = IDLE;
                end
            end
            default: estado_n = IDLE;
        endcase
        if (limpar) begin
            inc      = 1'b0;
            estado_n = IDLE;
        end
    end

    assign cont_done = (estado == ACK);
    assign caixa     = inc && (garrafas == ULTIMA);

    always_comb begin
        alarme_n = alarme;
        if (esvaziar) begin
            alarme_n = caixa && (LIMITE == 7'd1);
        end else if (caixa && (duzias == LIMITE_M1)) begin
            alarme_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            garrafas  <= '0;
            alarme    <= 1'b0;
            excedente <= 1'b0;
        end else begin
            if (limpar || caixa) begin
                garrafas <= '0;
            end else if (inc) begin
                garrafas <= garrafas + 4'd1;
            end
            alarme <= alarme_n;
            if (esvaziar) begin
                excedente <= 1'b0;
            end else if (estouro) begin
                excedente <= 1'b1;
            end
        end
    end

    contador_bcd_duzias u_duzias (
        .clk       (clk),
        .reset     (reset),
        .inc       (caixa),
        .clr       (esvaziar),
        .sat_limit (LIMITE),
        .binario   (duzias),
        .dezenas   (duzias_dez),
        .unidades  (duzias_uni),
        .estouro   (estouro)
    );

endmodule

// File: tb/tb_mef_contador.sv
// Bench for mef_contador: two instances (stock limits 10 and 2) driven in
// parallel and compared against a bottle/box arithmetic reference model.
module tb_mef_contador;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic count = 1'b0;
    logic limpar = 1'b0;
    logic esvaziar = 1'b0;

    logic       cd_a, al_a, ex_a, cd_b, al_b, ex_b;
    logic [3:0] g_a, g_b, dz_a, un_a, dz_b, un_b;
    logic [6:0] d_a, d_b;

    always #5 clk = ~clk;

    mef_contador #(.MAX_DUZIAS(10)) dut_a (
        .clk(clk), .reset(reset), .count(count), .limpar(limpar), .esvaziar(esvaziar),
        .cont_done(cd_a), .alarme(al_a), .garrafas(g_a), .duzias(d_a),
        .duzias_dez(dz_a), .duzias_uni(un_a), .excedente(ex_a)
    );

    mef_contador #(.MAX_DUZIAS(2)) dut_b (
        .clk(clk), .reset(reset), .count(count), .limpar(limpar), .esvaziar(esvaziar),
        .cont_done(cd_b), .alarme(al_b), .garrafas(g_b), .duzias(d_b),
        .duzias_dez(dz_b), .duzias_uni(un_b), .excedente(ex_b)
    );

    logic [21:0] obs_a, obs_b;
    assign obs_a = {cd_a, al_a, g_a, d_a, dz_a, un_a, ex_a};
    assign obs_b = {cd_b, al_b, g_b, d_b, dz_b, un_b, ex_b};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: request pending flag, bottles in box, boxes per instance.
    bit m_ack;
    int m_g;
    int m_d[2];
    bit m_x[2];
    int lim[2] = '{10, 2};

    task automatic model_reset();
        m_ack = 1'b0;
        m_g   = 0;
        for (int i = 0; i < 2; i++) begin
            m_d[i] = 0;
            m_x[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit c, input bit l, input bit e);
        bit novo;
        bit box;
        novo  = c && !m_ack && !l;
        m_ack = c && !l;
        box   = 1'b0;
        if (l) m_g = 0;
        else if (novo) begin
            m_g = m_g + 1;
            if (m_g == 12) begin
                m_g = 0;
                box = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (e) begin
                m_d[i] = 0;
                m_x[i] = 1'b0;
            end
            if (box) begin
                if (m_d[i] == lim[i]) m_x[i] = 1'b1;
                else m_d[i] = m_d[i] + 1;
            end
        end
    endtask

    function automatic logic [21:0] exp_vec(input int i);
        return {m_ack, (m_d[i] == lim[i]), 4'(m_g), 7'(m_d[i]),
                4'(m_d[i] / 10), 4'(m_d[i] % 10), m_x[i]};
    endfunction

    task automatic cycr(input bit c, input bit l, input bit e, input bit r);
        @(negedge clk);
        count = c; limpar = l; esvaziar = e; reset = r;
        @(posedge clk);
        if (r) model_edge(c, l, e);
        #1;
    endtask

    task automatic cyc(input bit c, input bit l, input bit e);
        cycr(c, l, e, 1'b1);
    endtask

    task automatic hs();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; count = 1'b0; limpar = 1'b0; esvaziar = 1'b0;
        model_reset();
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_cmp++;
        if ({obs_a, obs_b} !== 44'd0) begin
            n_err++;
            $display("FAIL reset_state got %h/%h want 0/0", obs_a, obs_b);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
            n_err++;
            $display("FAIL reset_release got %h/%h want %h/%h", obs_a, obs_b, exp_vec(0), exp_vec(1));
        end
    endtask

    task automatic test_hold();
        cyc(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (cd_a !== 1'b1 || g_a !== 4'd1) begin
            n_err++;
            $display("FAIL hold_first got cd=%b g=%0d want cd=1 g=1", cd_a, g_a);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (cd_a !== 1'b1 || g_a !== 4'd1 || obs_a !== exp_vec(0)) begin
            n_err++;
            $display("FAIL hold_5 got %h want %h (g=1, cd=1)", obs_a, exp_vec(0));
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (cd_a !== 1'b0 || g_a !== 4'd1) begin
            n_err++;
            $display("FAIL hold_release got cd=%b g=%0d want cd=0 g=1", cd_a, g_a);
        end
    endtask

    task automatic test_dozens();
        do_reset();
        for (int i = 0; i < 12; i++) hs();
        n_cmp++;
        if (g_a !== 4'd0 || d_a !== 7'd1 || dz_a !== 4'd0 || un_a !== 4'd1) begin
            n_err++;
            $display("FAIL dozens_12 got g=%0d d=%0d bcd=%0d/%0d want 0 1 0/1", g_a, d_a, dz_a, un_a);
        end
        for (int i = 0; i < 24; i++) hs();
        n_cmp++;
        if (d_a !== 7'd3 || {obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
            n_err++;
            $display("FAIL dozens_36 got %h/%h want %h/%h (d=3)", obs_a, obs_b, exp_vec(0), exp_vec(1));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 23; i++) hs();
        n_cmp++;
        if (al_b !== 1'b0 || d_b !== 7'd1) begin
            n_err++;
            $display("FAIL sat_pre got al=%b d=%0d want al=0 d=1", al_b, d_b);
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (al_b !== 1'b1 || d_b !== 7'd2 || al_a !== 1'b0) begin
            n_err++;
            $display("FAIL sat_alarm got al_b=%b d_b=%0d al_a=%b want 1 2 0", al_b, d_b, al_a);
        end
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) hs();
        n_cmp++;
        if (ex_b !== 1'b1 || d_b !== 7'd2 || g_b !== 4'd0 || al_b !== 1'b1 || ex_a !== 1'b0) begin
            n_err++;
            $display("FAIL sat_overflow got ex=%b d=%0d g=%0d al=%b ex_a=%b want 1 2 0 1 0",
                     ex_b, d_b, g_b, al_b, ex_a);
        end
    endtask

    task automatic test_bcd_carry();
        do_reset();
        for (int i = 0; i < 108; i++) hs();
        n_cmp++;
        if (d_a !== 7'd9 || dz_a !== 4'd0 || un_a !== 4'd9) begin
            n_err++;
            $display("FAIL bcd_nine got d=%0d bcd=%0d/%0d want 9 0/9", d_a, dz_a, un_a);
        end
        for (int i = 0; i < 11; i++) hs();
        cyc(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (d_a !== 7'd10 || dz_a !== 4'd1 || un_a !== 4'd0 || al_a !== 1'b1) begin
            n_err++;
            $display("FAIL bcd_carry got d=%0d bcd=%0d/%0d al=%b want 10 1/0 1", d_a, dz_a, un_a, al_a);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_esvaziar();
        for (int i = 0; i < 11; i++) hs();
        cyc(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (d_a !== 7'd1 || dz_a !== 4'd0 || un_a !== 4'd1 || al_a !== 1'b0 ||
            d_b !== 7'd1 || ex_b !== 1'b0 || al_b !== 1'b0 || g_a !== 4'd0) begin
            n_err++;
            $display("FAIL esvaziar_box got %h/%h want d=1 bcd 0/1 al=0 ex=0", obs_a, obs_b);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_limpar();
        for (int i = 0; i < 7; i++) hs();
        n_cmp++;
        if (g_a !== 4'd7) begin
            n_err++;
            $display("FAIL limpar_pre got g=%0d want 7", g_a);
        end
        cyc(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (g_a !== 4'd0 || d_a !== 7'd1 || d_b !== 7'd1) begin
            n_err++;
            $display("FAIL limpar got g=%0d d=%0d/%0d want 0 1/1", g_a, d_a, d_b);
        end
        cyc(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (g_a !== 4'd0 || cd_a !== 1'b0) begin
            n_err++;
            $display("FAIL limpar_req got g=%0d cd=%b want 0 0", g_a, cd_a);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        hs(); hs();
        cyc(1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({obs_a, obs_b} !== 44'd0) begin
            n_err++;
            $display("FAIL reset_async got %h/%h want 0/0", obs_a, obs_b);
        end
        cycr(1'b1, 1'b0, 1'b0, 1'b0);
        cycr(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (g_a !== 4'd1 || cd_a !== 1'b1 || d_a !== 7'd0) begin
            n_err++;
            $display("FAIL reset_recount got g=%0d cd=%b d=%0d want 1 1 0", g_a, cd_a, d_a);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 39) == 0));
            n_cmp++;
            if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
                n_err++;
                if (bad < 5)
                    $display("FAIL random_%0d got %h/%h want %h/%h", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_dozens();
        test_saturation();
        test_bcd_carry();
        test_esvaziar();
        test_limpar();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mef_contador.md
# mef_contador

Bottle-counting responder for the bottling line. It answers the main controller's `count` request with a level `cont_done` acknowledge. It counts accepted bottles in groups of 12 (one box) and keeps a dozens count in binary and BCD for the display. It raises `alarme` when the box stock reaches its limit, which stalls the main controller at the motor stage until an operator empties the stock.

## Interface
- MAX_DUZIAS, default 10: stock limit in boxes; legal range 1..99.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears everything.
- count  in  1  request level from the main controller; high while it waits in its counter stage.
- limpar  in  1  line restart (main controller's `resetar`); synchronous.
- esvaziar  in  1  operator "stock emptied" level; synchronous.
- cont_done  out  1  acknowledge level.
- alarme  out  1  stock full.
- garrafas  out  4  bottles in the current box, 0..11.
- duzias  out  7  completed boxes, binary, 0..MAX_DUZIAS.
- duzias_dez  out  4  BCD tens of `duzias`.
- duzias_uni  out  4  BCD units of `duzias`.
- excedente  out  1  sticky overflow flag.

## Operation
- Four-phase handshake FSM with two states:
  - IDLE: `cont_done`=0. If `count`=1, perform one increment and go to ACK.
  - ACK: `cont_done`=1. Stay while `count`=1. Go to IDLE on the first cycle `count`=0.
- Exactly one increment per request, no matter how long `count` is held.
- Increment rules:
  - If `garrafas` < 11, then `garrafas`+1.
  - Else `garrafas`←0 and the box completes: `duzias`+1 and the BCD pair is updated in the same edge.
  - If `duzias` already equals MAX_DUZIAS when a box completes, `duzias` holds its value, `garrafas` wraps to 0 and `excedente` sets.
- `alarme`=1 exactly when `duzias`==MAX_DUZIAS. It is registered from the same edge that updates `duzias`.
- `limpar` has the highest synchronous priority:
  - FSM←IDLE, `garrafas`←0, no increment that cycle.
  - `duzias`, BCD outputs, `alarme` and `excedente` are kept.
- `esvaziar`:
  - `duzias` and BCD←0, `alarme`←0, `excedente`←0.
  - If a box completes on the same edge, the result is `duzias`=1, BCD 0/1.
  - `garrafas` and the FSM are unaffected.
- `limpar` together with `esvaziar` in the same cycle: apply both.
- Reset mid-handshake: all outputs drop to 0 asynchronously. The FSM returns to IDLE, so a request still high after reset release is counted once.

## Timing
- Reset values: every output 0; FSM in IDLE.
- Latency: `count` sampled high at edge k. The counters update at edge k, and `cont_done` is high from edge k until the edge after `count` is seen low.
- The main controller leaves its counter stage at edge k+1, so `count` falls in that cycle and `cont_done` falls at edge k+2.
- Minimum handshake period is 2 cycles (IDLE→ACK→IDLE).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package: FSM state encodings (IDLE=1'b0, ACK=1'b1), the constant GARRAFAS_POR_CAIXA=12, and the 4-bit BCD digit width. The main controller uses the same package.
- One sub-module, `contador_bcd_duzias`:
  - Keeps the binary and BCD dozens counter together, with inputs inc, clr and sat-limit.
  - Outputs binary, tens, units and the overflow strobe.
- The top level holds the FSM, the bottle counter and the alarm/flag registers.

## Test plan
- Reset release with `count`=0, then `count` held high for 5 cycles → exactly one increment (`garrafas`=1); `cont_done` high from the sampling edge until one cycle after `count` drops.
- 12 back-to-back 2-cycle handshakes from zero → `garrafas` 0, `duzias`=1, BCD 0/1; 24 further handshakes → `duzias`=3.
- MAX_DUZIAS=2, 24 handshakes → `alarme`=1 on the completing edge; 12 more → `excedente`=1, `duzias` stays 2, `garrafas`=0.
- `duzias`=9 (BCD 0/9) plus one box → `duzias`=10, BCD 1/0 on the same edge.
- `esvaziar` on the same cycle as the 12th bottle's request → `duzias`=1, `alarme`=0; `limpar` at `garrafas`=7 → `garrafas`=0 with `duzias` unchanged.
- Reset asserted while in ACK with `count` held high → outputs 0 immediately; after release, one increment (`garrafas`=1).
